// File: rtl/sub_shift.sv
// AES SubBytes + ShiftRows stage with a column-serial S-box datapath and valid/ready on both sides.
// Define SUB_SHIFT_FAST_EN to substitute two columns per cycle (eight S-boxes instead of four).

module sub_shift_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      64'h637c777bf26b6fc5, 64'h3001672bfed7ab76,
      64'hca82c97dfa5947f0, 64'hadd4a2af9ca472c0,
      64'hb7fd9326363ff7cc, 64'h34a5e5f171d83115,
      64'h04c723c31896059a, 64'h071280e2eb27b275,
      64'h09832c1a1b6e5aa0, 64'h523bd6b329e32f84,
      64'h53d100ed20fcb15b, 64'h6acbbe394a4c58cf,
      64'hd0efaafb434d3385, 64'h45f9027f503c9fa8,
      64'h51a3408f929d38f5, 64'hbcb6da2110fff3d2,
      64'hcd0c13ec5f974417, 64'hc4a77e3d645d1973,
      64'h60814fdc222a9088, 64'h46eeb814de5e0bdb,
      64'he0323a0a4906245c, 64'hc2d3ac629195e479,
      64'he7c8376d8dd54ea9, 64'h6c56f4ea657aae08,
      64'hba78252e1ca6b4c6, 64'he8dd741f4bbd8b8a,
      64'h703eb5664803f60e, 64'h613557b986c11d9e,
      64'he1f8981169d98e94, 64'h9b1e87e9ce5528df,
      64'h8ca1890dbfe64268, 64'h41992d0fb054bb16
   };

   assign o_byte = SBOX_TABLE[{~i_byte, 3'b000} +: 8];
endmodule

module sub_shift (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

`ifdef SUB_SHIFT_FAST_EN
   localparam int unsigned LANES    = 8;
   localparam logic [1:0]  LAST_CNT = 2'd1;
`else
   localparam int unsigned LANES    = 4;
   localparam logic [1:0]  LAST_CNT = 2'd3;
`endif

   state_t             r_state;
   state_t             w_next_state;
   logic [1:0]         r_cnt;
   logic [127:0]       r_work;
   logic [127:0]       w_work_sub;
   logic [127:0]       r_data_out;
   logic               r_out_valid;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_last;
   logic [6:0]         w_lane_base;
   logic [LANES*8-1:0] w_lane_in;
   logic [LANES*8-1:0] w_lane_out;

   // Byte (r,c) sits at bits [127-32c-8r -: 8]; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] res;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
         end
      end
      return res;
   endfunction

`ifdef SUB_SHIFT_FAST_EN
   // r_cnt[0] selects the column pair: 0 -> columns 0/1, 1 -> columns 2/3.
   assign w_lane_base = {~r_cnt[0], 6'b000000};
`else
   assign w_lane_base = {~r_cnt, 5'b00000};
`endif

   assign w_lane_in = r_work[w_lane_base +: LANES*8];

   for (genvar g = 0; g < LANES; g++) begin : gen_sbox
      sub_shift_sbox u_sbox (
         .i_byte (w_lane_in[8*g +: 8]),
         .o_byte (w_lane_out[8*g +: 8])
      );
   end

   always_comb begin
      w_work_sub = r_work;
      w_work_sub[w_lane_base +: LANES*8] = w_lane_out;
   end

   assign w_last   = (r_cnt == LAST_CNT);
   assign w_accept = in_valid && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Handshake: a side transfers on a rising edge where its valid and ready are both high.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = ST_SUB;
            end
         end
         ST_SUB: begin
            if (w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_in_ready = out_ready;
            if (out_ready) begin
               w_next_state = in_valid ? ST_SUB : ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_work      <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_work <= data_in;
            r_cnt  <= '0;
         end else if (r_state == ST_SUB) begin
            r_work <= w_work_sub;
            r_cnt  <= r_cnt + 2'd1;
         end

         if ((r_state == ST_SUB) && w_last) begin
            r_data_out  <= shift_rows(w_work_sub);
            r_out_valid <= 1'b1;
         end else if ((r_state == ST_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign data_out  = r_data_out;
   assign busy      = (r_state != ST_IDLE);
endmodule

// File: doc/sub_shift.md
SUB_SHIFT -- requirements
Module: sub_shift

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert handled externally.
REQ-003 in_valid  input  1  data_in holds a valid 128-bit AES state.
REQ-004 in_ready  output  1  block accepts data_in this cycle; transfer when in_valid && in_ready at rising edge.
REQ-005 data_in  input  128  AES state, column-major: [127:96]=column 0 ... [31:0]=column 3; within column, [31:24]=row 0 ... [7:0]=row 3.
REQ-006 out_valid  output  1  data_out holds SubBytes+ShiftRows result; feeds mixcolumn data_in directly.
REQ-007 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at rising edge.
REQ-008 data_out  output  128  result, same packing as data_in; registered.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 Shall compute data_out byte(r,c) = S(data_in byte(r,(c+r) mod 4)), S = FIPS-197 forward S-box.
REQ-011 S-box: GF(2^8) inverse modulo 0x11B (inverse of 00 = 00) followed by affine transform with constant 0x63, or equivalent 256-entry table; results bit-identical.
REQ-012 FSM states IDLE, SUB, DONE; reset state IDLE.
REQ-013 IDLE: in_ready=1; on transfer capture data_in into working register, column counter cnt=0, go SUB.
REQ-014 SUB: each cycle substitute the column(s) selected by cnt in place, cnt increments; in_ready=0.
REQ-015 SUB exit: on edge processing last column, load data_out with ShiftRows of fully substituted state, out_valid=1, go DONE.
REQ-016 DONE: data_out and out_valid held stable until out_ready=1.
REQ-017 DONE with out_ready=1 and in_valid=0: out_valid clears, go IDLE.
REQ-018 DONE with out_ready=1 and in_valid=1: in_ready=1 (combinational from out_ready); output retired and new block captured on same edge, go SUB (back-to-back).
REQ-019 DONE with out_ready=0: in_ready=0; in_valid ignored.
REQ-020 Latency default build: out_valid rises 4 cycles after accepting edge; throughput one block per 5 cycles with out_ready held high.
REQ-021 cnt width 2 bits; wraps to 0 on re-entry to SUB; no other wrap behaviour observable.
REQ-022 data_in sampled only at accepting edge; later changes to data_in shall not affect result.

Reset
REQ-023 rst_n=0 shall immediately force: state=IDLE, cnt=0, working register=0, data_out=128'h0, out_valid=0, busy=0; in_ready=1 after deassert.
REQ-024 Reset during SUB or DONE shall discard the block in flight; no partial output ever appears.

Configuration
REQ-025 Macro SUB_SHIFT_FAST_EN: when defined, 8 S-box instances, two columns per SUB cycle, latency 2 cycles, throughput one block per 3 cycles.
REQ-026 Without SUB_SHIFT_FAST_EN: 4 S-box instances, one column per SUB cycle, latency per REQ-020; function and interface identical in both builds.

Verification
REQ-027 data_in=128'h193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> data_out=128'hd4bf5d30e0b452aeb84111f11e2798e5, out_valid at +4 cycles (+2 with SUB_SHIFT_FAST_EN).
REQ-028 data_in=128'h0 -> data_out=128'h63636363636363636363636363636363; data_in all 8'h53 -> all 8'hed.
REQ-029 out_ready=0 for 10 cycles after out_valid, in_valid=1 throughout -> data_out stable, in_ready=0, then one transfer each side on out_ready edge, next result 4 cycles later.
REQ-030 Back-to-back 3 blocks with in_valid=out_ready=1 continuously -> 3 correct outputs, each out_valid pulse 1 cycle, 5-cycle spacing (3 with fast build).
REQ-031 rst_n pulsed low 2 cycles after accepting a block -> out_valid stays 0, data_out=0, next accepted block produces correct result with nominal latency.
